// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch controller: drives pc to instruction memory, fills the IF/ID
// register, and handles stalls, EX redirects, end-of-program drain and fetch faults.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [31:0] HALT_PC      = 32'd40,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned IMEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_flag,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] inp_instn,
  output logic [31:0] pc,
  output logic [31:0] if_id_instn,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_nextpc,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_t;

  localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES);
  localparam logic [30:0] WORD_LIMIT = 31'(IMEM_WORDS);

  state_t     state;
  state_t     state_next;
  logic [3:0] drain_cnt;

  logic addr_fault;
  logic do_fetch;
  logic do_redirect;
  logic do_end;
  logic do_fault;
  logic do_drain_step;

  assign addr_fault = (pc[1:0] != 2'b00) || ({1'b0, pc[31:2]} >= WORD_LIMIT);
  assign halted     = (state == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:  state_next = RUN;
      RUN: begin
        if (do_end) begin
          state_next = DRAIN;
        end else if (do_fault) begin
          state_next = HALT;
        end
      end
      DRAIN: begin
        if (do_redirect) begin
          state_next = RUN;
        end else if (do_drain_step && (drain_cnt == DRAIN_LAST)) begin
          state_next = HALT;
        end
      end
      HALT:  state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // Redirect beats stall beats fetch; the target is only range-checked when it is fetched.
  always_comb begin
    do_fetch      = 1'b0;
    do_redirect   = 1'b0;
    do_end        = 1'b0;
    do_fault      = 1'b0;
    do_drain_step = 1'b0;
    unique case (state)
      RUN: begin
        if (branch_taken) begin
          do_redirect = 1'b1;
        end else if (stall_flag) begin
          do_fetch = 1'b0;
        end else if (pc == HALT_PC) begin
          do_end = 1'b1;
        end else if (addr_fault) begin
          do_fault = 1'b1;
        end else begin
          do_fetch = 1'b1;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          do_redirect = 1'b1;
        end else if (!stall_flag) begin
          do_drain_step = 1'b1;
        end
      end
      default: do_fetch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      if_id_instn  <= 32'd0;
      if_id_pc     <= 32'd0;
      if_id_nextpc <= 32'd0;
      if_id_valid  <= 1'b0;
      fetch_err    <= 1'b0;
      fetch_count  <= 32'd0;
      drain_cnt    <= 4'd0;
    end else begin
      if (do_redirect) begin
        pc          <= branch_target;
        if_id_valid <= 1'b0;
        drain_cnt   <= 4'd0;
      end
      if (do_fetch) begin
        if_id_instn  <= inp_instn;
        if_id_pc     <= pc;
        if_id_nextpc <= pc + 32'd4;
        if_id_valid  <= 1'b1;
        pc           <= pc + 32'd4;
        fetch_count  <= fetch_count + 32'd1;
      end
      if (do_end) begin
        if_id_valid <= 1'b0;
        drain_cnt   <= 4'd1;
      end
      if (do_fault) begin
        fetch_err   <= 1'b1;
        if_id_valid <= 1'b0;
      end
      if (do_drain_step && (drain_cnt != DRAIN_LAST)) begin
        drain_cnt <= drain_cnt + 4'd1;
      end
    end
  end

endmodule
